// File: rtl/pixel_fetch.sv
// pixel_fetch: turns corrected source coordinates into frame-buffer reads and
// streams the fetched pixels out in arrival order with line/frame markers.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   xIn, yIn, addr_vld    source coordinate from the distortion stage
//   mem_ready             space available, to the upstream handshake
//   mem_en, mem_addr      BRAM read request
//   mem_rdata             BRAM data, RD_LAT cycles after mem_en
//   pix_t*                AXI-Stream style pixel output (tlast = end of line,
//                         tuser = first pixel of frame)
//   ovf_err               sticky: a coordinate arrived with no space left
module pixel_fetch #(
  parameter int              IMG_W      = 1080,
  parameter int              IMG_H      = 960,
  parameter int              ADDR_W     = 20,
  parameter int              PIX_W      = 16,
  parameter int              FIFO_DEPTH = 8,
  parameter int              RD_LAT     = 2,
  parameter logic [PIX_W-1:0] FILL      = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       xIn,
  input  logic [11:0]       yIn,
  input  logic              addr_vld,
  output logic              mem_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_tdata,
  output logic              pix_tvalid,
  input  logic              pix_tready,
  output logic              pix_tlast,
  output logic              pix_tuser,
  output logic              ovf_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 2;            // room to count past FIFO_DEPTH on overflow
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Address stage. Arithmetic is done at ADDR_W so truncation is modular.
  logic [ADDR_W-1:0] lin, addr_q;
  logic              oob_in;
  assign lin    = ADDR_W'(yIn) * ADDR_W'(IMG_W) + ADDR_W'(xIn);
  assign oob_in = (xIn >= 12'(IMG_W)) | (yIn >= 12'(IMG_H));

  // [0] is the address-stage register, [RD_LAT] lines up with mem_rdata.
  logic [RD_LAT:0] vld_pipe, oob_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      oob_pipe <= '0;
      addr_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], addr_vld};
      oob_pipe <= {oob_pipe[RD_LAT-1:0], oob_in};
      if (addr_vld) addr_q <= lin;
    end
  end

  assign mem_en   = vld_pipe[0] & ~oob_pipe[0];
  assign mem_addr = addr_q;

  // Output FIFO; pointers carry one extra wrap bit.
  logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             fifo_wr, xfer;

  assign fifo_wr    = vld_pipe[RD_LAT];
  assign pix_tvalid = (wr_ptr != rd_ptr);
  assign xfer       = pix_tvalid & pix_tready;

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr[PW-1:0]] <= oob_pipe[RD_LAT] ? FILL : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (xfer)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy spans address stage, read pipeline and FIFO, so mem_ready
  // can throttle upstream before the FIFO itself fills.
  logic [OW-1:0] occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ     <= '0;
      ovf_err <= 1'b0;
    end else begin
      case ({addr_vld, xfer})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (addr_vld && occ >= OW'(FIFO_DEPTH)) ovf_err <= 1'b1;
    end
  end

  // One slot of slack covers the coordinate already in flight upstream.
  assign mem_ready = ~reset & (occ <= OW'(FIFO_DEPTH - 2));

  // Raster position of the pixel currently at the FIFO head.
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Gated with tvalid so an empty FIFO shows all-zero outputs.
  assign pix_tdata = pix_tvalid ? fifo_mem[rd_ptr[PW-1:0]] : '0;
  assign pix_tlast = pix_tvalid & (col == CW'(IMG_W - 1));
  assign pix_tuser = pix_tvalid & (col == '0) & (row == '0);

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch on a reduced 40x6 image so whole frames fit in a
// short run. A queue-based model predicts every output cycle by cycle.
module tb_pixel_fetch;
  localparam int W = 40, H = 6, FD = 8, RD_LAT = 2, ADDR_W = 20, PIX_W = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic [11:0] xIn = '0, yIn = '0;
  logic addr_vld = 1'b0, pix_tready = 1'b0;
  logic mem_ready, mem_en, pix_tvalid, pix_tlast, pix_tuser, ovf_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata, pix_tdata;

  always #5 clk = ~clk;

  pixel_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
                .FIFO_DEPTH(FD), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .xIn(xIn), .yIn(yIn), .addr_vld(addr_vld),
    .mem_ready(mem_ready), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .pix_tdata(pix_tdata), .pix_tvalid(pix_tvalid),
    .pix_tready(pix_tready), .pix_tlast(pix_tlast), .pix_tuser(pix_tuser),
    .ovf_err(ovf_err));

  // Frame-buffer contents: address 85 (x=5,y=2) holds ABCD, else nonzero.
  function automatic logic [15:0] bram(input int a);
    return (a == 85) ? 16'hABCD : 16'(a * 7 + 16'h1234);
  endfunction

  logic [PIX_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? bram(int'(mem_addr)) : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state
  typedef struct { logic [15:0] d; int land; } ent_t;
  ent_t q[$];
  int   m_occ = 0, m_idx = 0;
  bit   m_ovf = 0, pv_vld = 0, pv_oob = 0, chk_en = 0;
  int   pv_addr = 0;
  int   n_men = 0, n_zero = 0, n_last = 0, n_user = 0, n_xfer = 0;

  always @(negedge clk) begin
    bit exp_v, oob;
    int a;
    exp_v = (q.size() > 0) && (q[0].land <= cyc);
    if (chk_en) begin
      chk("mem_en", mem_en, pv_vld && !pv_oob);
      if (pv_vld && !pv_oob) chk("mem_addr", mem_addr, pv_addr);
      chk("mem_ready", mem_ready, !reset && m_occ <= FD - 2);
      chk("ovf_err", ovf_err, m_ovf);
      chk("pix_tvalid", pix_tvalid, exp_v);
      if (exp_v) begin
        chk("pix_tdata", pix_tdata, q[0].d);
        chk("pix_tlast", pix_tlast, (m_idx % W) == W - 1);
        chk("pix_tuser", pix_tuser, (m_idx % (W * H)) == 0);
      end
      if (mem_en) n_men++;
      if (exp_v && pix_tready) begin
        n_xfer++;
        if (pix_tdata == 0) n_zero++;
        if (pix_tlast) n_last++;
        if (pix_tuser) n_user++;
      end
    end
    if (reset) begin
      q.delete(); m_occ = 0; m_idx = 0; m_ovf = 0; pv_vld = 0;
    end else begin
      if (addr_vld && m_occ >= FD) m_ovf = 1;
      if (exp_v && pix_tready) begin void'(q.pop_front()); m_idx++; m_occ--; end
      oob = (xIn >= W) || (yIn >= H);
      a   = (int'(yIn) * W + int'(xIn)) % (1 << ADDR_W);
      if (addr_vld) begin
        q.push_back('{d: oob ? 16'h0 : bram(a), land: cyc + RD_LAT + 2});
        m_occ++;
        pv_addr = a;
      end
      pv_vld = addr_vld;
      pv_oob = oob;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input int x, input int y);
    step(); addr_vld = v; xIn = 12'(x); yIn = 12'(y);
  endtask

  task automatic do_reset();
    step(); addr_vld = 1'b0; reset = 1'b1;
    step(); step(); reset = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (m_occ != 0 && t < 3000) begin step(); addr_vld = 1'b0; t++; end
    chk("drain_timeout", t < 3000, 1'b1);
  endtask

  task automatic clr_cnt();
    n_men = 0; n_zero = 0; n_last = 0; n_user = 0; n_xfer = 0;
  endtask

  logic go;
  int p, acc, guard;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    step(); step(); step();
    reset = 1'b0; chk_en = 1;
    @(negedge clk);
    chk("rst_tvalid", pix_tvalid, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_ovf", ovf_err, 1'b0);

    // 1: single coordinate, mem_addr = 2*40+5
    pix_tready = 1'b1;
    drive(1, 5, 2);
    drive(0, 0, 0);
    @(negedge clk);
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_addr", mem_addr, 85);
    step(); step(); @(negedge clk);
    chk("t1_early_tvalid", pix_tvalid, 1'b0);
    step(); @(negedge clk);
    chk("t1_tvalid", pix_tvalid, 1'b1);
    chk("t1_tdata", pix_tdata, 16'hABCD);
    chk("t1_tuser", pix_tuser, 1'b1);
    wait_drain();

    // 2: out-of-range coordinates interleaved with (0,0)
    clr_cnt();
    drive(1, W, 0); drive(1, 0, 0); drive(1, 0, H); drive(1, 0, 0); drive(1, 4095, 4095);
    drive(0, 0, 0);
    wait_drain();
    chk("t2_mem_en_count", n_men, 2);
    chk("t2_fill_count", n_zero, 3);

    // 3: backpressure with registered upstream handshake
    clr_cnt();
    pix_tready = 1'b0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      go = mem_ready;
      drive(go, i, 1);
      if (go) acc++;
    end
    drive(0, 0, 0);
    @(negedge clk);
    chk("t3_accepted", acc, 8);
    chk("t3_mem_ready", mem_ready, 1'b0);
    chk("t3_ovf", ovf_err, 1'b0);
    pix_tready = 1'b1;
    wait_drain();
    chk("t3_drained", n_xfer, 8);

    // 4: full frame plus 3 pixels of the next, random ready and gaps
    do_reset(); clr_cnt();
    p = 0; guard = 0;
    while (p < W * H + 3 && guard < 20000) begin
      go = mem_ready && ($urandom_range(3) != 0);
      drive(go, p % W, (p / W) % H);
      pix_tready = 1'($urandom_range(1));
      if (go) p++;
      guard++;
    end
    chk("t4_feed_timeout", guard < 20000, 1'b1);
    drive(0, 0, 0); pix_tready = 1'b1;
    wait_drain();
    chk("t4_pixels", n_xfer, W * H + 3);
    chk("t4_tlast_count", n_last, H);
    chk("t4_tuser_count", n_user, 2);

    // 5: overflow ignoring mem_ready (FIFO contents corrupt, model paused)
    do_reset(); chk_en = 0; pix_tready = 1'b0;
    for (int i = 0; i < 9; i++) drive(1, i, 0);
    @(negedge clk);
    chk("t5_ovf_before", ovf_err, 1'b0);
    drive(0, 0, 0);
    @(negedge clk);
    chk("t5_ovf_set", ovf_err, 1'b1);
    pix_tready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    chk("t5_ovf_sticky", ovf_err, 1'b1);
    do_reset();
    @(negedge clk);
    chk("t5_ovf_cleared", ovf_err, 1'b0);
    chk_en = 1;

    // 6: reset with 5 entries in flight
    pix_tready = 1'b0;
    for (int i = 0; i < 5; i++) drive(1, i + 1, 1);
    step(); addr_vld = 1'b0; reset = 1'b1;
    step(); @(negedge clk);
    chk("t6_mem_en", mem_en, 1'b0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_tvalid", pix_tvalid, 1'b0);
    chk("t6_tdata", pix_tdata, 0);
    chk("t6_tlast", pix_tlast, 1'b0);
    chk("t6_tuser", pix_tuser, 1'b0);
    chk("t6_mem_ready", mem_ready, 1'b0);
    chk("t6_ovf", ovf_err, 1'b0);
    step(); reset = 1'b0; pix_tready = 1'b1; addr_vld = 1'b1; xIn = 12'd1; yIn = 12'd0;
    drive(0, 0, 0);
    @(negedge clk);
    chk("t6_new_addr", mem_addr, 1);
    step(); step(); step(); @(negedge clk);
    chk("t6_new_tvalid", pix_tvalid, 1'b1);
    chk("t6_new_tuser", pix_tuser, 1'b1);
    chk("t6_new_tdata", pix_tdata, 16'h123B);
    wait_drain();

    // 7: random coordinates (some out of range), random ready
    for (int i = 0; i < 300; i++) begin
      go = mem_ready && ($urandom_range(2) != 0);
      if ($urandom_range(15) == 0) drive(go, 4095, $urandom_range(4095));
      else drive(go, $urandom_range(W + 4), $urandom_range(H + 2));
      pix_tready = 1'($urandom_range(1));
    end
    drive(0, 0, 0); pix_tready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
